// File: rtl/mem_arb_pkg.sv
// Shared definitions for the program/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_WORD_W = 10;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_P0   = 2'b01,
    OWN_P1   = 2'b10
  } owner_e;

endpackage

// File: rtl/mem_arb_rport.sv
// Per-port read-return register: latches memory data on a read ack and
// pulses rvalid for the following cycle.
module mem_arb_rport
  import mem_arb_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ack,
  input  logic              we,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] rdata,
  output logic              rvalid
);

  // rdata is held between reads so the requester can sample it late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= ack & ~we;
      if (ack & ~we) rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter for the single-port program/data memory,
// with a bounded burst length and registered read return per port.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [WORD_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [WORD_W-1:0] p0_rdata,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [WORD_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [WORD_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  owner_e           own_q;
  owner_e           last_q;
  logic [CNT_W-1:0] cnt_q;

  logic             own_req;
  logic             oth_req;
  owner_e           other;
  logic [CNT_W-1:0] cnt_inc;

  assign owner  = own_q;
  assign p0_ack = (own_q == OWN_P0) & p0_req;
  assign p1_ack = (own_q == OWN_P1) & p1_req;

  assign own_req = (own_q == OWN_P0) ? p0_req : p1_req;
  assign oth_req = (own_q == OWN_P0) ? p1_req : p0_req;
  assign other   = (own_q == OWN_P0) ? OWN_P1 : OWN_P0;
  assign cnt_inc = cnt_q + 1'b1;

  // Memory pins follow the owner's fields; idle bus is driven to zero.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    case (own_q)
      OWN_P0: begin
        mem_addr  = p0_addr;
        mem_wdata = p0_wdata;
        mem_write = p0_ack & p0_we;
      end
      OWN_P1: begin
        mem_addr  = p1_addr;
        mem_wdata = p1_wdata;
        mem_write = p1_ack & p1_we;
      end
      default: ;
    endcase
  end

  // Ownership hands over without an idle cycle; a full burst yields only to a waiting peer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q  <= OWN_NONE;
      last_q <= OWN_P1;
      cnt_q  <= '0;
    end else begin
      case (own_q)
        OWN_NONE: begin
          cnt_q <= '0;
          if (p0_req && p1_req) own_q <= (last_q == OWN_P0) ? OWN_P1 : OWN_P0;
          else if (p0_req)      own_q <= OWN_P0;
          else if (p1_req)      own_q <= OWN_P1;
        end
        default: begin
          if (!own_req) begin
            last_q <= own_q;
            cnt_q  <= '0;
            own_q  <= oth_req ? other : OWN_NONE;
          end else if (cnt_inc == BURST_LIM) begin
            cnt_q <= '0;
            if (oth_req) begin
              last_q <= own_q;
              own_q  <= other;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
      endcase
    end
  end

  mem_arb_rport #(.WORD_W(WORD_W)) u_rport0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ack       (p0_ack),
    .we        (p0_we),
    .mem_rdata (mem_rdata),
    .rdata     (p0_rdata),
    .rvalid    (p0_rvalid)
  );

  mem_arb_rport #(.WORD_W(WORD_W)) u_rport1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ack       (p1_ack),
    .we        (p1_we),
    .mem_rdata (mem_rdata),
    .rdata     (p1_rdata),
    .rvalid    (p1_rvalid)
  );

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: external memory model, queued requesters and a
// transaction-level reference of grants, memory contents and read returns.
module tb_memory_arbiter;

  localparam int MB = 4;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [9:0] wdata;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drv_req [2];
  logic       drv_we [2];
  logic [7:0] drv_addr [2];
  logic [9:0] drv_wdata [2];

  logic       p0_ack, p1_ack, p0_rvalid, p1_rvalid, mem_write;
  logic [9:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic [7:0] mem_addr;
  logic [1:0] owner;

  logic [9:0] tb_mem [256];
  logic [9:0] ref_mem [256];

  txn_t q0[$];
  txn_t q1[$];
  bit   active [2];
  bit   ack_prev [2];
  int   ack_log[$];

  int         mo, mlast, mcnt;
  logic       exp_rv [2];
  logic [9:0] exp_rd [2];

  int checks = 0;
  int failures = 0;

  memory_arbiter #(.WORD_W(10), .ADDR_W(8), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (drv_req[0]),
    .p0_we     (drv_we[0]),
    .p0_addr   (drv_addr[0]),
    .p0_wdata  (drv_wdata[0]),
    .p0_ack    (p0_ack),
    .p0_rdata  (p0_rdata),
    .p0_rvalid (p0_rvalid),
    .p1_req    (drv_req[1]),
    .p1_we     (drv_we[1]),
    .p1_addr   (drv_addr[1]),
    .p1_wdata  (drv_wdata[1]),
    .p1_ack    (p1_ack),
    .p1_rdata  (p1_rdata),
    .p1_rvalid (p1_rvalid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  // Single-port memory: combinational read, write on the rising edge.
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_write) tb_mem[mem_addr] <= mem_wdata;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", tag, act, expv);
    end
  endtask

  task automatic modelReset();
    mo = 0; mlast = 2; mcnt = 0;
    for (int i = 0; i < 2; i++) begin
      exp_rv[i] = 1'b0; exp_rd[i] = '0; ack_prev[i] = 0;
    end
  endtask

  task automatic applyStimulus(input bit gaps);
    txn_t t;
    for (int i = 0; i < 2; i++) begin
      if (ack_prev[i]) begin
        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        active[i] = 0;
        ack_prev[i] = 0;
      end
      if (!active[i] && (((i == 0) ? q0.size() : q1.size()) > 0) &&
          (!gaps || $urandom_range(0, 2) != 0))
        active[i] = 1;
      if (active[i]) begin
        t = (i == 0) ? q0[0] : q1[0];
        drv_we[i] = t.we; drv_addr[i] = t.addr; drv_wdata[i] = t.wdata;
      end
      drv_req[i] = active[i];
    end
  endtask

  // Compare this cycle's outputs with the reference, then advance it by one edge.
  task automatic stepModel();
    bit   ea [2];
    int   o, oth;
    logic ew;
    logic [7:0] ea_addr;
    logic [9:0] ea_wd;
    ea[0] = (mo == 1) && drv_req[0];
    ea[1] = (mo == 2) && drv_req[1];
    o = (mo == 0) ? 0 : mo - 1;
    ew      = (mo != 0) && ea[o] && drv_we[o];
    ea_addr = (mo != 0) ? drv_addr[o] : 8'h00;
    ea_wd   = (mo != 0) ? drv_wdata[o] : 10'h000;
    checkOutput("owner", owner, mo);
    checkOutput("p0_ack", p0_ack, ea[0]);
    checkOutput("p1_ack", p1_ack, ea[1]);
    checkOutput("mem_write", mem_write, ew);
    checkOutput("mem_addr", mem_addr, ea_addr);
    checkOutput("mem_wdata", mem_wdata, ea_wd);
    checkOutput("p0_rvalid", p0_rvalid, exp_rv[0]);
    checkOutput("p0_rdata", p0_rdata, exp_rd[0]);
    checkOutput("p1_rvalid", p1_rvalid, exp_rv[1]);
    checkOutput("p1_rdata", p1_rdata, exp_rd[1]);
    ack_log.push_back(p0_ack ? 1 : (p1_ack ? 2 : 0));

    for (int i = 0; i < 2; i++) begin
      exp_rv[i] = ea[i] && !drv_we[i];
      if (exp_rv[i]) exp_rd[i] = ref_mem[drv_addr[i]];
      ack_prev[i] = ea[i];
    end
    if (ew) ref_mem[ea_addr] = ea_wd;

    if (mo == 0) begin
      mcnt = 0;
      if (drv_req[0] && drv_req[1]) mo = (mlast == 1) ? 2 : 1;
      else if (drv_req[0])          mo = 1;
      else if (drv_req[1])          mo = 2;
    end else begin
      oth = 3 - mo;
      if (!drv_req[mo-1]) begin
        mlast = mo; mcnt = 0;
        mo = drv_req[oth-1] ? oth : 0;
      end else begin
        mcnt++;
        if (mcnt == MB) begin
          mcnt = 0;
          if (drv_req[oth-1]) begin mlast = mo; mo = oth; end
        end
      end
    end
  endtask

  task automatic runCycle(input bit gaps);
    @(negedge clk);
    stepModel();
    @(posedge clk);
    #1;
    applyStimulus(gaps);
  endtask

  task automatic runUntilIdle(input bit gaps, input int maxc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < maxc) begin
      runCycle(gaps);
      n++;
    end
    checkOutput("idle_timeout", (n >= maxc) ? 1 : 0, 0);
    runCycle(gaps);
    runCycle(gaps);
  endtask

  task automatic pushTxn(input int port, input logic we, input logic [7:0] addr, input logic [9:0] wd);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wd;
    if (port == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  initial begin
    int first, cnt1;
    logic [9:0] v, orig;
    for (int i = 0; i < 256; i++) begin
      v = 10'($urandom);
      if (i == 8'h71) v = 10'd5;
      tb_mem[i] <= v;
      ref_mem[i] = v;
    end
    for (int i = 0; i < 2; i++) begin
      active[i] = 0; drv_req[i] = 0; drv_we[i] = 0; drv_addr[i] = '0; drv_wdata[i] = '0;
    end
    modelReset();

    // Reset held with both ports requesting; also sets up the fairness burst.
    for (int k = 0; k < 12; k++) begin
      pushTxn(0, 1'b0, 8'(k), 10'h0);
      pushTxn(1, 1'b0, 8'(8'h80 + k), 10'h0);
    end
    applyStimulus(0);
    repeat (2) @(negedge clk);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_p0_ack", p0_ack, 0);
    checkOutput("rst_p1_ack", p1_ack, 0);
    checkOutput("rst_mem_write", mem_write, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_p0_rvalid", p0_rvalid, 0);
    checkOutput("rst_p1_rvalid", p1_rvalid, 0);
    checkOutput("rst_p0_rdata", p0_rdata, 0);
    checkOutput("rst_p1_rdata", p1_rdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    ack_log.delete();
    runUntilIdle(0, 100);
    for (int k = 0; k <= 24; k++)
      checkOutput($sformatf("fair_%0d", k), ack_log[k], (k == 0) ? 0 : ((((k - 1) / MB) % 2 == 0) ? 1 : 2));

    // Single read of the preloaded word.
    ack_log.delete();
    pushTxn(0, 1'b0, 8'h71, 10'h0);
    runUntilIdle(0, 20);
    checkOutput("single_rd_wait", ack_log[1], 0);
    checkOutput("single_rd_ack", ack_log[2], 1);
    checkOutput("single_rd_data", p0_rdata, 10'd5);

    // Write then read back on port 1.
    pushTxn(1, 1'b1, 8'h70, 10'h3FF);
    pushTxn(1, 1'b0, 8'h70, 10'h0);
    runUntilIdle(0, 20);
    checkOutput("wr_rd_data", p1_rdata, 10'h3FF);
    checkOutput("wr_rd_mem", tb_mem[8'h70], 10'h3FF);

    // Solo burst longer than MAX_BURST.
    ack_log.delete();
    for (int k = 0; k < 10; k++) pushTxn(0, 1'b0, 8'(8'h10 + k), 10'h0);
    runUntilIdle(0, 40);
    first = -1; cnt1 = 0;
    foreach (ack_log[k]) if (ack_log[k] == 1) begin
      if (first < 0) first = k;
      cnt1++;
    end
    checkOutput("solo_count", cnt1, 10);
    checkOutput("solo_first", first, 2);
    checkOutput("solo_last", ack_log[first + 9], 1);
    checkOutput("solo_release", owner, 0);

    // Randomised traffic with idle gaps between transactions.
    for (int k = 0; k < 60; k++) begin
      pushTxn(0, 1'($urandom), 8'($urandom), 10'($urandom));
      pushTxn(1, 1'($urandom), 8'($urandom), 10'($urandom));
    end
    runUntilIdle(1, 2000);

    // Reset asserted during the third write of a port-1 burst.
    for (int k = 0; k < 4; k++)
      pushTxn(1, 1'b1, 8'(8'h50 + k), ref_mem[8'h50 + k] ^ 10'h3FF);
    repeat (4) runCycle(0);
    #1;
    checkOutput("mid_ack", p1_ack, 1);
    checkOutput("mid_addr", mem_addr, 8'h52);
    orig = tb_mem[8'h52];
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_write", mem_write, 0);
    checkOutput("mid_rst_ack", p1_ack, 0);
    checkOutput("mid_rst_owner", owner, 0);
    checkOutput("mid_rst_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    checkOutput("mid_rst_mem", tb_mem[8'h52], orig);
    checkOutput("mid_rst_done51", tb_mem[8'h51], ref_mem[8'h51]);
    checkOutput("mid_rst_owner2", owner, 0);
    checkOutput("mid_rst_rvalid", p1_rvalid, 0);
    q0.delete(); q1.delete();
    for (int i = 0; i < 2; i++) begin active[i] = 0; drv_req[i] = 0; end
    modelReset();
    rst_n = 1'b1;
    pushTxn(0, 1'b0, 8'h52, 10'h0);
    runUntilIdle(0, 20);
    checkOutput("post_rst_read", p0_rdata, orig);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
